// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: per-register in-flight write counters that stall issue
// on source hazards and on counter/global saturation, retired by rf writeback traffic.
module rf_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 6,
  parameter bit BYPASS_EN    = 1'b0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_issue_valid,
  output logic                                  o_issue_ready,
  input  logic [4:0]                            i_issue_rs1,
  input  logic                                  i_issue_rs1_used,
  input  logic [4:0]                            i_issue_rs2,
  input  logic                                  i_issue_rs2_used,
  input  logic                                  i_issue_rd_wen,
  input  logic [4:0]                            i_issue_rd,
  input  logic                                  i_rd_wen,
  input  logic [4:0]                            i_rd_waddr,
  input  logic                                  i_flush,
  output logic                                  o_rs1_busy,
  output logic                                  o_rs2_busy,
  output logic [31:0]                           o_busy_mask,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     o_inflight,
  output logic                                  o_err
);

  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);
  localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [31:0]      busy_mask_q, busy_mask_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic             rs1_bypass, rs2_bypass;
  logic             rs1_busy, rs2_busy, rd_block;
  logic             issue_ready, fire, issue_inc;
  logic             retire, retire_miss, same_reg;

  // Source hazards; with bypass, a writeback retiring the last pending write clears it.
  always_comb begin
    rs1_cnt    = cnt_q[i_issue_rs1];
    rs2_cnt    = cnt_q[i_issue_rs2];
    rs1_bypass = BYPASS_EN && i_rd_wen && (i_rd_waddr == i_issue_rs1) && (rs1_cnt == CNT_ONE);
    rs2_bypass = BYPASS_EN && i_rd_wen && (i_rd_waddr == i_issue_rs2) && (rs2_cnt == CNT_ONE);
    rs1_busy   = i_issue_rs1_used && (i_issue_rs1 != 5'd0) && (rs1_cnt != '0) && !rs1_bypass;
    rs2_busy   = i_issue_rs2_used && (i_issue_rs2 != 5'd0) && (rs2_cnt != '0) && !rs2_bypass;
  end

  always_comb begin
    rd_cnt      = cnt_q[i_issue_rd];
    wb_cnt      = cnt_q[i_rd_waddr];
    rd_block    = i_issue_rd_wen && (i_issue_rd != 5'd0) &&
                  ((rd_cnt == CNT_MAX) || (inflight_q == INF_MAX));
    issue_ready = !i_rst && !i_flush && !rs1_busy && !rs2_busy && !rd_block;
    fire        = i_issue_valid && issue_ready;
    issue_inc   = fire && i_issue_rd_wen && (i_issue_rd != 5'd0);
    retire      = i_rd_wen && (i_rd_waddr != 5'd0) && (wb_cnt != '0);
    retire_miss = i_rd_wen && (i_rd_waddr != 5'd0) && (wb_cnt == '0);
    same_reg    = issue_inc && retire && (i_issue_rd == i_rd_waddr);
  end

  // Flush wipes all tracking but leaves the sticky error flag alone.
  always_comb begin
    for (int n = 0; n < 32; n++) begin
      cnt_d[n] = cnt_q[n];
    end
    inflight_d = inflight_q;
    err_d      = err_q;
    if (i_flush) begin
      for (int n = 0; n < 32; n++) begin
        cnt_d[n] = '0;
      end
      inflight_d = '0;
    end else begin
      if (issue_inc && !same_reg) begin
        cnt_d[i_issue_rd] = rd_cnt + CNT_ONE;
      end
      if (retire && !same_reg) begin
        cnt_d[i_rd_waddr] = wb_cnt - CNT_ONE;
      end
      if (issue_inc && !retire) begin
        inflight_d = inflight_q + INF_ONE;
      end else if (retire && !issue_inc) begin
        inflight_d = inflight_q - INF_ONE;
      end
      if (retire_miss) begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy_mask_d = '0;
    for (int n = 1; n < 32; n++) begin
      busy_mask_d[n] = (cnt_d[n] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 32; n++) begin
        cnt_q[n] <= '0;
      end
      inflight_q  <= '0;
      busy_mask_q <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      busy_mask_q <= busy_mask_d;
      err_q       <= err_d;
    end
  end

  assign o_issue_ready = issue_ready;
  assign o_rs1_busy    = rs1_busy;
  assign o_rs2_busy    = rs2_busy;
  assign o_busy_mask   = busy_mask_q;
  assign o_inflight    = inflight_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: two instances (bypass off / on) share stimulus and are
// compared each cycle against a counter-array model, plus hand-computed directed checks.
module tb_rf_scoreboard;

  localparam int CNT_LIMIT = 3;
  localparam int INF_LIMIT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, issueValid, rs1Used, rs2Used, issueRdWen, rdWen, flush;
  logic [4:0] rs1, rs2, issueRd, rdWaddr;

  logic        dReady [2];
  logic        dRs1Busy [2];
  logic        dRs2Busy [2];
  logic        dErr [2];
  logic [31:0] dMask [2];
  logic [2:0]  dInflight [2];

  int   mCnt [2][32];
  logic mErr [2];
  logic checkEn = 1'b0;
  int   errCount = 0;
  int   checkCount = 0;

  rf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(6), .BYPASS_EN(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_issue_valid(issueValid), .o_issue_ready(dReady[0]),
    .i_issue_rs1(rs1), .i_issue_rs1_used(rs1Used), .i_issue_rs2(rs2), .i_issue_rs2_used(rs2Used),
    .i_issue_rd_wen(issueRdWen), .i_issue_rd(issueRd), .i_rd_wen(rdWen), .i_rd_waddr(rdWaddr),
    .i_flush(flush), .o_rs1_busy(dRs1Busy[0]), .o_rs2_busy(dRs2Busy[0]),
    .o_busy_mask(dMask[0]), .o_inflight(dInflight[0]), .o_err(dErr[0]));

  rf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(6), .BYPASS_EN(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_issue_valid(issueValid), .o_issue_ready(dReady[1]),
    .i_issue_rs1(rs1), .i_issue_rs1_used(rs1Used), .i_issue_rs2(rs2), .i_issue_rs2_used(rs2Used),
    .i_issue_rd_wen(issueRdWen), .i_issue_rd(issueRd), .i_rd_wen(rdWen), .i_rd_waddr(rdWaddr),
    .i_flush(flush), .o_rs1_busy(dRs1Busy[1]), .o_rs2_busy(dRs2Busy[1]),
    .o_busy_mask(dMask[1]), .o_inflight(dInflight[1]), .o_err(dErr[1]));

  function automatic int modelSum(int k);
    int s = 0;
    for (int n = 0; n < 32; n++) s += mCnt[k][n];
    return s;
  endfunction

  function automatic logic [31:0] modelMask(int k);
    logic [31:0] m = '0;
    for (int n = 1; n < 32; n++) m[n] = (mCnt[k][n] != 0);
    return m;
  endfunction

  function automatic logic modelSrcBusy(int k, logic used, logic [4:0] rs);
    if (!used || rs == 5'd0 || mCnt[k][rs] == 0) return 1'b0;
    if (k == 1 && rdWen && rdWaddr == rs && mCnt[k][rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic modelReady(int k);
    logic blk;
    blk = issueRdWen && issueRd != 5'd0 &&
          (mCnt[k][issueRd] == CNT_LIMIT || modelSum(k) == INF_LIMIT);
    return !rst && !flush && !modelSrcBusy(k, rs1Used, rs1) &&
           !modelSrcBusy(k, rs2Used, rs2) && !blk;
  endfunction

  function automatic int modelInc(int k);
    if (issueValid && modelReady(k) && issueRdWen && issueRd != 5'd0) return int'(issueRd);
    return -1;
  endfunction

  function automatic int modelDec(int k);
    if (rdWen && rdWaddr != 5'd0 && mCnt[k][rdWaddr] != 0) return int'(rdWaddr);
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int n = 0; n < 32; n++) mCnt[k][n] <= 0;
        mErr[k] <= 1'b0;
      end else if (flush) begin
        for (int n = 0; n < 32; n++) mCnt[k][n] <= 0;
      end else begin
        if (modelInc(k) >= 0 && modelInc(k) != modelDec(k))
          mCnt[k][modelInc(k)] <= mCnt[k][modelInc(k)] + 1;
        if (modelDec(k) >= 0 && modelDec(k) != modelInc(k))
          mCnt[k][modelDec(k)] <= mCnt[k][modelDec(k)] - 1;
        if (rdWen && rdWaddr != 5'd0 && mCnt[k][rdWaddr] == 0)
          mErr[k] <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("ready", k, 32'(dReady[k]), 32'(modelReady(k)));
        checkOutput("rs1Busy", k, 32'(dRs1Busy[k]), 32'(modelSrcBusy(k, rs1Used, rs1)));
        checkOutput("rs2Busy", k, 32'(dRs2Busy[k]), 32'(modelSrcBusy(k, rs2Used, rs2)));
        checkOutput("busyMask", k, dMask[k], modelMask(k));
        checkOutput("inflight", k, 32'(dInflight[k]), 32'(modelSum(k)));
        checkOutput("err", k, 32'(dErr[k]), 32'(mErr[k]));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2, input logic rdw,
                               input logic [4:0] rd, input logic wbw, input logic [4:0] wa,
                               input logic fl, input logic rs);
    issueValid = v;  rs1 = r1;  rs1Used = u1;  rs2 = r2;  rs2Used = u2;
    issueRdWen = rdw; issueRd = rd; rdWen = wbw; rdWaddr = wa; flush = fl; rst = rs;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBoth(input string name, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] exp);
    checkOutput(name, 0, a0, exp);
    checkOutput(name, 1, a1, exp);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    checkBoth("rstReady", 32'(dReady[0]), 32'(dReady[1]), 0);
    nextCycle();
    checkEn = 1'b1;

    // Basic hazard, x0 writeback ignored, bypass contrast between instances.
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0); #2;
    checkBoth("postRstReady", 32'(dReady[0]), 32'(dReady[1]), 1);
    checkBoth("postRstMask", dMask[0], dMask[1], 0);
    checkBoth("postRstInfl", 32'(dInflight[0]), 32'(dInflight[1]), 0);
    nextCycle();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    checkBoth("rs1Hazard", 32'(dRs1Busy[0]), 32'(dRs1Busy[1]), 1);
    checkBoth("hazardReady", 32'(dReady[0]), 32'(dReady[1]), 0);
    checkBoth("maskRd5", dMask[0], dMask[1], 32'h20);
    checkBoth("x0NoErr", 32'(dErr[0]), 32'(dErr[1]), 0);
    nextCycle();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0); #2;
    checkOutput("noBypassBusy", 0, 32'(dRs1Busy[0]), 1);
    checkOutput("bypassBusy", 1, 32'(dRs1Busy[1]), 0);
    checkOutput("bypassReady", 1, 32'(dReady[1]), 1);
    nextCycle();
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    checkBoth("retiredReady", 32'(dReady[0]), 32'(dReady[1]), 1);
    checkBoth("retiredInfl", 32'(dInflight[0]), 32'(dInflight[1]), 0);

    // Per-register saturation at 3 outstanding writes.
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); #2;
      checkBoth("satReady", 32'(dReady[0]), 32'(dReady[1]), (i < 3) ? 1 : 0);
      checkBoth("satInfl", 32'(dInflight[0]), 32'(dInflight[1]), 32'(i));
    end
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 0); #2;
    checkBoth("retireNoRelief", 32'(dReady[0]), 32'(dReady[1]), 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); #2;
    checkBoth("satReadyBack", 32'(dReady[0]), 32'(dReady[1]), 1);
    checkBoth("satInfl2", 32'(dInflight[0]), 32'(dInflight[1]), 2);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0); #2;
      checkBoth("drainInfl", 32'(dInflight[0]), 32'(dInflight[1]), 32'(3 - i));
    end

    // Global in-flight limit.
    for (int i = 1; i <= 6; i++) begin
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 1, 5'(i), 0, 0, 0, 0); #2;
      checkBoth("fillReady", 32'(dReady[0]), 32'(dReady[1]), 1);
    end
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0); #2;
    checkBoth("limitReady", 32'(dReady[0]), 32'(dReady[1]), 0);
    checkBoth("limitInfl", 32'(dInflight[0]), 32'(dInflight[1]), 6);
    checkBoth("limitMask", dMask[0], dMask[1], 32'h7E);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0); #2;
    checkBoth("noRdReady", 32'(dReady[0]), 32'(dReady[1]), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 1, 4, 0, 0); #2;
    checkBoth("sameRegReady", 32'(dReady[0]), 32'(dReady[1]), 1);
    checkBoth("sameRegInflPre", 32'(dInflight[0]), 32'(dInflight[1]), 5);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0); #2;
    checkBoth("sameRegInfl", 32'(dInflight[0]), 32'(dInflight[1]), 5);
    checkBoth("sameRegMask", dMask[0], dMask[1], 32'h3E);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); #2;
    checkBoth("errSet", 32'(dErr[0]), 32'(dErr[1]), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    checkBoth("errSticky", 32'(dErr[0]), 32'(dErr[1]), 1);

    // Flush, then reset with the error flag set.
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0); #2;
    checkBoth("flushReady", 32'(dReady[0]), 32'(dReady[1]), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    checkBoth("flushMask", dMask[0], dMask[1], 0);
    checkBoth("flushInfl", 32'(dInflight[0]), 32'(dInflight[1]), 0);
    checkBoth("flushKeepsErr", 32'(dErr[0]), 32'(dErr[1]), 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1); #2;
    checkBoth("midRstReady", 32'(dReady[0]), 32'(dReady[1]), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    checkBoth("rstErr", 32'(dErr[0]), 32'(dErr[1]), 0);
    checkBoth("rstInfl", 32'(dInflight[0]), 32'(dInflight[1]), 0);

    // Random traffic over a small register window to force frequent hazards.
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      applyStimulus(($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 63) == 0), ($urandom_range(0, 511) == 0));
    end
    nextCycle();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
